// File: rtl/stack_ctrl_pkg.sv
// Shared types and constants for the stack arbiter: FSM states, op codes
// and requester indices.
package stack_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin grant: on a tie the requester that was
// not served last wins; a lone requester always wins.
module rr_arbiter_2
    import stack_ctrl_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic valid,
    output logic grant
);

    // NOTE: both outputs get a default before any branch so no latch is inferred.
    always_comb begin
        valid = req_a | req_b;
        grant = REQ_A;
        if (req_a && req_b) begin
            grant = (last == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            grant = REQ_B;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin push/pop arbiter for a shared LIFO stack (IDLE -> ISSUE -> RESP).
// Optional saturating error counter enabled by STACK_ARB_ERR_COUNT_EN.
module stack_arbiter
    import stack_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  op_a,
    input  logic                  op_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_a,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_wdata,
    input  logic                  stk_empty,
    input  logic                  stk_full,
    input  logic [DATA_WIDTH-1:0] stk_rdata
`ifdef STACK_ARB_ERR_COUNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    state_t state, state_next;
    logic   sel, sel_next;
    logic   last, last_next;
    logic   grant_valid, grant;
    logic   win_op;
    logic   push_next, pop_next, ack_a_next, ack_b_next, err_next;
    logic [DATA_WIDTH-1:0] rdata_next, wdata_next;

    rr_arbiter_2 u_rr (
        .req_a (req_a),
        .req_b (req_b),
        .last  (last),
        .valid (grant_valid),
        .grant (grant)
    );

    // Status is sampled on the edge that enters ISSUE, so strobes, err and
    // rdata are decided in IDLE and registered for the ISSUE cycle.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        last_next  = last;
        wdata_next = stk_wdata;
        rdata_next = rdata;
        err_next   = err;
        push_next  = 1'b0;
        pop_next   = 1'b0;
        ack_a_next = 1'b0;
        ack_b_next = 1'b0;
        win_op     = (grant == REQ_B) ? op_b : op_a;

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                    sel_next   = grant;
                    wdata_next = (grant == REQ_B) ? wdata_b : wdata_a;
                    if (win_op == OP_PUSH) begin
                        err_next   = stk_full;
                        push_next  = ~stk_full;
                        rdata_next = '0;
                    end else begin
                        err_next   = stk_empty;
                        pop_next   = ~stk_empty;
                        rdata_next = stk_empty ? '0 : stk_rdata;
                    end
                end
            end
            ISSUE: begin
                state_next = RESP;
                ack_a_next = (sel == REQ_A);
                ack_b_next = (sel == REQ_B);
            end
            RESP: begin
                state_next = IDLE;
                last_next  = sel;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sel       <= REQ_A;
            last      <= REQ_B;
            stk_wdata <= '0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            last      <= last_next;
            stk_wdata <= wdata_next;
            stk_push  <= push_next;
            stk_pop   <= pop_next;
            ack_a     <= ack_a_next;
            ack_b     <= ack_b_next;
            rdata     <= rdata_next;
            err       <= err_next;
        end
    end

    assign busy = (state != IDLE);

`ifdef STACK_ARB_ERR_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= 8'd0;
        end else if (state == RESP && err && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: a behavioural 4-deep stack on the
// strobes, plus an independent transaction-level reference model.
module tb_stack_arbiter;
    import stack_ctrl_pkg::*;

    localparam int DW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0, op_a = 1'b0, op_b = 1'b0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          ack_a, ack_b, err, busy, stk_push, stk_pop;
    logic [DW-1:0] rdata, stk_wdata;
    logic          stk_empty = 1'b1, stk_full = 1'b0;
    logic [DW-1:0] stk_rdata = '0;
`ifdef STACK_ARB_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif

    stack_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .op_a      (op_a),
        .op_b      (op_b),
        .wdata_a   (wdata_a),
        .wdata_b   (wdata_b),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_wdata (stk_wdata),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_rdata (stk_rdata)
`ifdef STACK_ARB_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment stack driven by the DUT strobes.
    logic [DW-1:0] env_q[$];
    always @(posedge clk) begin
        if (stk_push && env_q.size() < DEPTH) env_q.push_back(stk_wdata);
        if (stk_pop && env_q.size() > 0) void'(env_q.pop_back());
        stk_empty <= (env_q.size() == 0);
        stk_full  <= (env_q.size() == DEPTH);
        stk_rdata <= (env_q.size() > 0) ? env_q[$] : '0;
    end

    // Reference model state
    logic [DW-1:0] model_q[$];
    logic          last_served = REQ_B;
    int            exp_errs = 0;
    int            ack_cyc = 0, prev_ack_cyc = 0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE, ends at the negedge of the following IDLE.
    task automatic transact(input logic ra, input logic rb, input logic oa, input logic ob,
                            input logic [DW-1:0] wa, input logic [DW-1:0] wb);
        logic          win, op, exp_err;
        logic [DW-1:0] wd, exp_rd;
        check("busy_idle", {31'd0, busy}, 32'd0);
`ifdef STACK_ARB_ERR_COUNT_EN
        check("err_count", {24'd0, err_count}, exp_errs);
`endif
        req_a = ra; req_b = rb; op_a = oa; op_b = ob; wdata_a = wa; wdata_b = wb;
        if (ra && rb) win = (last_served == REQ_A) ? REQ_B : REQ_A;
        else          win = ra ? REQ_A : REQ_B;
        op = (win == REQ_B) ? ob : oa;
        wd = (win == REQ_B) ? wb : wa;
        if (op == OP_PUSH) begin
            exp_err = (model_q.size() == DEPTH);
            exp_rd  = '0;
        end else begin
            exp_err = (model_q.size() == 0);
            exp_rd  = exp_err ? '0 : model_q[$];
        end

        @(negedge clk);
        check("stk_push", {31'd0, stk_push}, {31'd0, (op == OP_PUSH) && !exp_err});
        check("stk_pop",  {31'd0, stk_pop},  {31'd0, (op == OP_POP) && !exp_err});
        if (op == OP_PUSH && !exp_err) check("stk_wdata", {28'd0, stk_wdata}, {28'd0, wd});
        check("ack_early", {30'd0, ack_a, ack_b}, 32'd0);
        check("busy_issue", {31'd0, busy}, 32'd1);

        @(negedge clk);
        check("ack_a", {31'd0, ack_a}, {31'd0, win == REQ_A});
        check("ack_b", {31'd0, ack_b}, {31'd0, win == REQ_B});
        check("rdata", {28'd0, rdata}, {28'd0, exp_rd});
        check("err",   {31'd0, err},   {31'd0, exp_err});
        check("strobes_resp", {30'd0, stk_push, stk_pop}, 32'd0);
        prev_ack_cyc = ack_cyc;
        ack_cyc      = cyc;

        if (!exp_err) begin
            if (op == OP_PUSH) model_q.push_back(wd);
            else void'(model_q.pop_back());
        end
        if (exp_err && exp_errs < 255) exp_errs++;
        last_served = win;

        @(negedge clk);
    endtask

    task automatic idle_cycle();
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        check("idle_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    logic          ra = 1'b0, rb = 1'b0, oa = 1'b0, ob = 1'b0;
    logic [DW-1:0] wa = '0, wb = '0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outs", {26'd0, ack_a, ack_b, err, busy, stk_push, stk_pop}, 32'd0);
        check("rst_data", {24'd0, rdata, stk_wdata}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
`ifdef STACK_ARB_ERR_COUNT_EN
        check("rst_err_count", {24'd0, err_count}, 32'd0);
`endif

        transact(1'b1, 1'b0, OP_PUSH, OP_PUSH, 4'h5, 4'h0);
        transact(1'b0, 1'b1, OP_PUSH, OP_POP, 4'h0, 4'h0);
        transact(1'b0, 1'b1, OP_PUSH, OP_POP, 4'h0, 4'h0);
        idle_cycle();

        for (int i = 0; i < 4; i++) begin
            transact(1'b1, 1'b1, OP_PUSH, OP_PUSH, 4'h1, 4'h2);
            check("tie_order", {31'd0, last_served}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i > 0) check("tie_spacing", ack_cyc - prev_ack_cyc, 32'd3);
        end

        transact(1'b1, 1'b0, OP_PUSH, OP_PUSH, 4'h7, 4'h0);
`ifdef STACK_ARB_ERR_COUNT_EN
        for (int i = 0; i < 300; i++) transact(1'b0, 1'b1, OP_PUSH, OP_PUSH, 4'h0, 4'hC);
        idle_cycle();
        check("err_count_sat", {24'd0, err_count}, 32'd255);
`else
        for (int i = 0; i < 3; i++) transact(1'b0, 1'b1, OP_PUSH, OP_PUSH, 4'h0, 4'hC);
        idle_cycle();
`endif

        for (int i = 0; i < 4; i++) transact(1'b1, 1'b0, OP_POP, OP_PUSH, 4'h0, 4'h0);
        idle_cycle();

        // Reset asserted during ISSUE
        req_a = 1'b1; op_a = OP_PUSH; wdata_a = 4'h9;
        @(negedge clk);
        check("midrst_push_before", {31'd0, stk_push}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        check("midrst_ack", {30'd0, ack_a, ack_b}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        req_a = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        last_served = REQ_B;
        exp_errs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_ack", {30'd0, ack_a, ack_b}, 32'd0);
            check("postrst_busy", {31'd0, busy}, 32'd0);
        end

        // Random traffic; an unserved requester keeps its request pending.
        for (int i = 0; i < 80; i++) begin
            if (!ra) begin
                ra = 1'($urandom_range(0, 1));
                oa = 1'($urandom_range(0, 1));
                wa = DW'($urandom_range(0, 15));
            end
            if (!rb) begin
                rb = 1'($urandom_range(0, 1));
                ob = 1'($urandom_range(0, 1));
                wb = DW'($urandom_range(0, 15));
            end
            if (!ra && !rb) begin
                idle_cycle();
            end else begin
                transact(ra, rb, oa, ob, wa, wb);
                if (last_served == REQ_A) ra = 1'b0;
                else rb = 1'b0;
            end
        end
        idle_cycle();
        check("final_depth", env_q.size(), model_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
